// File: rtl/ahb_lite_regfile_slave_if.sv
// AHB-Lite bus bundle between one master and the register-file responder.
// HREADY is the bus-level ready returned to every slave on the segment.
interface ahb_lite_regfile_slave_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              HSEL;
   logic [ADDR_W-1:0] HADDR;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [3:0]        HPROT;
   logic [1:0]        HTRANS;
   logic              HREADY;
   logic              HREADYOUT;
   logic              HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_lite_regfile_slave.sv
// AHB-Lite word-organised register file with programmable wait states and
// two-cycle ERROR responses; every beat is handled independently.
module ahb_lite_regfile_slave #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input logic                 HCLK,
   input logic                 HRESETn,
   ahb_lite_regfile_slave_if.slave ahb
);
   localparam int         IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               readyOut_q, resp_q;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic               wrPend_q, wrPend_d;
   logic [IDX_W-1:0]   wrIdx_q, wrIdx_d;
   logic [3:0]         wrMask_q, wrMask_d;

   logic               accept;
   logic               decErr;
   logic               commit;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         mask;
   logic [DATA_W-1:0]  commitWord;

   // Own readiness is included so a misbehaving HREADY cannot cut a wait short.
   assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & readyOut_q;
   assign idx    = ahb.HADDR[IDX_W+1:2];
   assign commit = (state_q == S_LAST) & wrPend_q;

   always_comb begin
      decErr = 1'b0;
      mask   = 4'hF;
      if (ahb.HADDR >= ADDR_W'(DEPTH * 4)) decErr = 1'b1;
      case (ahb.HSIZE)
         3'd0: mask = 4'b0001 << ahb.HADDR[1:0];
         3'd1: begin
            mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            if (ahb.HADDR[0]) decErr = 1'b1;
         end
         3'd2: if (ahb.HADDR[1:0] != 2'b00) decErr = 1'b1;
         default: decErr = 1'b1;
      endcase
   end

   always_comb begin
      commitWord = mem_q[wrIdx_q];
      for (int b = 0; b < 4; b++) begin
         if (wrMask_q[b]) commitWord[8*b +: 8] = ahb.HWDATA[8*b +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wrPend_d = wrPend_q & (state_q != S_LAST);
      wrIdx_d  = wrIdx_q;
      wrMask_d = wrMask_q;
      rdata_d  = rdata_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_LAST;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1:         state_d = S_ERR2;
         S_LAST, S_ERR2: state_d = S_IDLE;
         default:        state_d = S_IDLE;
      endcase
      // A new address phase overrides LAST/ERR2/IDLE, giving pipelined beats.
      if (accept) begin
         wrPend_d = ahb.HWRITE & ~decErr;
         wrIdx_d  = idx;
         wrMask_d = mask;
         if (decErr) begin
            state_d = S_ERR1;
         end else if (WS == 4'd0) begin
            state_d = S_LAST;
         end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
         end
         if (!decErr && !ahb.HWRITE) begin
            rdata_d = (commit && (wrIdx_q == idx)) ? commitWord : mem_q[idx];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         readyOut_q <= 1'b1;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
         wrPend_q   <= 1'b0;
         wrIdx_q    <= '0;
         wrMask_q   <= 4'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         readyOut_q <= (state_d == S_IDLE) | (state_d == S_LAST) | (state_d == S_ERR2);
         resp_q     <= (state_d == S_ERR1) | (state_d == S_ERR2);
         rdata_q    <= rdata_d;
         wrPend_q   <= wrPend_d;
         wrIdx_q    <= wrIdx_d;
         wrMask_q   <= wrMask_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit) begin
         mem_q[wrIdx_q] <= commitWord;
      end
   end

   assign ahb.HRDATA    = rdata_q;
   assign ahb.HREADYOUT = readyOut_q;
   assign ahb.HRESP     = resp_q;
endmodule
